mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and data requesters, the arbiter,
// and the shared single-port RAM.
interface mem_port_arbiter_if #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_valid;
  logic [REG_WIDTH-1:0]  if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [REG_WIDTH-1:0]  d_wdata;
  logic                  d_gnt;
  logic                  d_valid;
  logic [REG_WIDTH-1:0]  d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [REG_WIDTH-1:0]  mem_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // requesters plus RAM side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch, data) for one single-port RAM with 1-cycle read latency.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int REG_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  if (MAX_DATA_RUN < 1) begin : g_bad_run
    $error("MAX_DATA_RUN must be at least 1");
  end

  owner_e                owner_q, owner_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  if_gnt_q, if_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic                  grant_f, grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
`endif

  always_comb begin
    grant_d     = bus.d_req;
    grant_f     = bus.if_req && !bus.d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
    // fetch has waited through a full data run: let it through once
    if (bus.d_req && bus.if_req && (run_cnt_q == RUN_MAX)) begin
      grant_d = 1'b0;
      grant_f = 1'b1;
    end
    run_cnt_d = run_cnt_q;
    if (!bus.if_req || grant_f) begin
      run_cnt_d = '0;
    end else if (grant_d && (run_cnt_q != RUN_MAX)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
`endif

    mem_en_d    = grant_d || grant_f;
    mem_we_d    = grant_d && bus.d_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = grant_f;
    d_gnt_d     = grant_d;
    owner_d     = OWN_NONE;
    if (grant_d) begin
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      if (!bus.d_we) owner_d = OWN_DATA;
    end else if (grant_f) begin
      mem_addr_d = bus.if_addr;
      owner_d    = OWN_FETCH;
    end

    // the RAM word for the access issued last cycle appears this cycle
    if_valid_d = (owner_q == OWN_FETCH);
    d_valid_d  = (owner_q == OWN_DATA);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner_q     <= OWN_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      run_cnt_q   <= '0;
`endif
    end else begin
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      run_cnt_q   <= run_cnt_d;
`endif
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Expected grant pattern follows MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_port_arbiter;

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.REG_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  mem_port_arbiter #(
    .REG_WIDTH   (32),
    .ADDR_WIDTH  (12),
    .MAX_DATA_RUN(4)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  logic [31:0] ram [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM preloaded with 0xA000_0000 + address
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
    chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 0);
    chk({tag, "_d_gnt"}, 32'(bus.d_gnt), 0);
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 0);
    chk({tag, "_d_valid"}, 32'(bus.d_valid), 0);
  endtask

  logic [9:0] exp_f;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + 32'(i);
    bus.mem_rdata = '0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    n_reset     = 1'b0;
    #2;
    chk_idle("rst");
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    chk_idle("post_rst");

    // fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    tick();
    chk("f_gnt", 32'(bus.if_gnt), 1);
    chk("f_d_gnt", 32'(bus.d_gnt), 0);
    chk("f_mem_en", 32'(bus.mem_en), 1);
    chk("f_mem_we", 32'(bus.mem_we), 0);
    chk("f_mem_addr", 32'(bus.mem_addr), 32'h010);
    chk("f_early_valid", 32'(bus.if_valid), 0);
    bus.if_req = 1'b0;
    tick();
    chk("f_valid", 32'(bus.if_valid), 1);
    chk("f_rdata", bus.if_rdata, 32'hA000_0010);
    chk("f_d_valid", 32'(bus.d_valid), 0);
    chk("f_gnt_drop", 32'(bus.if_gnt), 0);
    chk("f_mem_en_drop", 32'(bus.mem_en), 0);
    tick();
    chk("f_valid_drop", 32'(bus.if_valid), 0);

    // contended: data load wins, fetch next
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h040;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'h020;
    tick();
    chk("c_d_gnt", 32'(bus.d_gnt), 1);
    chk("c_if_gnt0", 32'(bus.if_gnt), 0);
    chk("c_addr0", 32'(bus.mem_addr), 32'h020);
    bus.d_req = 1'b0;
    tick();
    chk("c_if_gnt", 32'(bus.if_gnt), 1);
    chk("c_d_gnt_drop", 32'(bus.d_gnt), 0);
    chk("c_addr1", 32'(bus.mem_addr), 32'h040);
    chk("c_d_valid", 32'(bus.d_valid), 1);
    chk("c_d_rdata", bus.d_rdata, 32'hA000_0020);
    chk("c_if_valid0", 32'(bus.if_valid), 0);
    bus.if_req = 1'b0;
    tick();
    chk("c_if_valid", 32'(bus.if_valid), 1);
    chk("c_if_rdata", bus.if_rdata, 32'hA000_0040);
    chk("c_d_valid_drop", 32'(bus.d_valid), 0);
    tick();
    chk_idle("c_end");

    // store then load back
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 12'h005;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("s_gnt", 32'(bus.d_gnt), 1);
    chk("s_mem_en", 32'(bus.mem_en), 1);
    chk("s_mem_we", 32'(bus.mem_we), 1);
    chk("s_addr", 32'(bus.mem_addr), 32'h005);
    chk("s_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    bus.d_wdata = 32'h0;
    tick();
    chk("s_d_valid", 32'(bus.d_valid), 0);
    chk("s_we_drop", 32'(bus.mem_we), 0);
    chk("s_addr_hold", 32'(bus.mem_addr), 32'h005);
    chk("s_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("s_d_valid2", 32'(bus.d_valid), 0);
    bus.d_req = 1'b1;
    tick();
    chk("l_gnt", 32'(bus.d_gnt), 1);
    chk("l_mem_we", 32'(bus.mem_we), 0);
    bus.d_req = 1'b0;
    tick();
    chk("l_valid", 32'(bus.d_valid), 1);
    chk("l_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    tick();

    // sustained contention
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_f = 10'b10000_10000;
`else
    exp_f = 10'b00000_00000;
`endif
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h100;
    bus.d_req   = 1'b1;
    bus.d_addr  = 12'h200;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("run%0d_if_gnt", i), 32'(bus.if_gnt), 32'(exp_f[i]));
      chk($sformatf("run%0d_d_gnt", i), 32'(bus.d_gnt), 32'(!exp_f[i]));
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    tick();
    tick();
    chk_idle("run_end");

    // reset while a load is in flight
    bus.d_req  = 1'b1;
    bus.d_addr = 12'h020;
    tick();
    chk("r_gnt", 32'(bus.d_gnt), 1);
    bus.d_req = 1'b0;
    n_reset   = 1'b0;
    #1;
    chk_idle("r_low");
    chk("r_low_mem_addr", 32'(bus.mem_addr), 0);
    tick();
    chk_idle("r_low2");
    n_reset = 1'b1;
    tick();
    chk("r_no_d_valid", 32'(bus.d_valid), 0);
    chk("r_no_if_valid", 32'(bus.if_valid), 0);
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    tick();
    chk("r_f_gnt", 32'(bus.if_gnt), 1);
    chk("r_f_addr", 32'(bus.mem_addr), 32'h010);
    bus.if_req = 1'b0;
    tick();
    chk("r_f_valid", 32'(bus.if_valid), 1);
    chk("r_f_rdata", bus.if_rdata, 32'hA000_0010);
    chk("r_f_d_valid", 32'(bus.d_valid), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
